// File: rtl/babbage_arbiter.sv
// babbage_arbiter: two-requester round-robin front end for one shared difference engine.
// Optional feature macro: BABBAGE_ARB_TIMEOUT_EN (abort a BUSY job after TIMEOUT_CYCLES).

package babbage_arbiter_pkg;
    localparam int unsigned COEF_W = 36;
    localparam int unsigned RES_W  = 32;

    // Job coefficients as carried on coef0/coef1/eng_coef, MSB first
    typedef struct packed {
        logic signed [1:0] a;
        logic signed [2:0] b;
        logic signed [3:0] c;
        logic signed [3:0] d;
        logic signed [5:0] f;
        logic signed [9:0] g;
        logic        [6:0] n;
    } coef_t;
endpackage

module babbage_arbiter
    import babbage_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    req1,
    input  logic [COEF_W-1:0]       coef0,
    input  logic [COEF_W-1:0]       coef1,
    output logic                    ack0,
    output logic                    ack1,
    output logic                    done0,
    output logic                    done1,
    output logic signed [RES_W-1:0] result,
    output logic                    err,
    output logic                    busy,
    output logic                    gnt,
    output logic                    eng_start,
    output logic [COEF_W-1:0]       eng_coef,
    input  logic                    eng_ready,
    input  logic                    eng_done,
    input  logic signed [RES_W-1:0] eng_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    ack0_d, ack1_d, done0_d, done1_d;
    logic                    start_d, busy_d, gnt_d;
    logic                    rr_q, rr_d;      // requester served last
    logic                    pick;
    coef_t                   coef_q, coef_d;
    logic signed [RES_W-1:0] result_d;

`ifdef BABBAGE_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign err = err_q;
`else
    logic unused_timeout;

    // No watchdog in this build: the limit is unused and err never rises
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign err            = 1'b0;
`endif

    assign eng_coef = coef_q;

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        start_d  = 1'b0;
        gnt_d    = gnt;
        rr_d     = rr_q;
        coef_d   = coef_q;
        result_d = result;
        pick     = 1'b0;
`ifdef BABBAGE_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if ((req0 || req1) && eng_ready) begin
                    // On a tie the requester not served last wins
                    pick    = (req0 && req1) ? ~rr_q : req1;
                    ack0_d  = ~pick;
                    ack1_d  = pick;
                    gnt_d   = pick;
                    rr_d    = pick;
                    coef_d  = pick ? coef_t'(coef1) : coef_t'(coef0);
                    start_d = 1'b1;
                    state_d = S_LAUNCH;
`ifdef BABBAGE_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_LAUNCH: begin
                state_d = S_BUSY;
`ifdef BABBAGE_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_BUSY: begin
                if (eng_done) begin
                    result_d = eng_out;
                    done0_d  = ~gnt;
                    done1_d  = gnt;
                    state_d  = S_RESP;
                end
`ifdef BABBAGE_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(LIMIT)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done0_d  = ~gnt;
                    done1_d  = gnt;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            eng_start <= 1'b0;
            busy      <= 1'b0;
            gnt       <= 1'b0;
            rr_q      <= 1'b1;
            coef_q    <= '0;
            result    <= '0;
`ifdef BABBAGE_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ack0      <= ack0_d;
            ack1      <= ack1_d;
            done0     <= done0_d;
            done1     <= done1_d;
            eng_start <= start_d;
            busy      <= busy_d;
            gnt       <= gnt_d;
            rr_q      <= rr_d;
            coef_q    <= coef_d;
            result    <= result_d;
`ifdef BABBAGE_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    // Protocol sanity: pulses are one-hot and the engine is only started from LAUNCH
    a_ack_onehot:  assert property (@(posedge clk) disable iff (!reset) !(ack0 && ack1));
    a_done_onehot: assert property (@(posedge clk) disable iff (!reset) !(done0 && done1));
    a_start_state: assert property (@(posedge clk) disable iff (!reset) eng_start |-> (state_q == S_LAUNCH));

endmodule

// File: tb/tb_babbage_arbiter.sv
// Bench for babbage_arbiter with a behavioural difference-engine stub and a transaction model.
module tb_babbage_arbiter;
    import babbage_arbiter_pkg::*;

`ifdef BABBAGE_ARB_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 1023;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [35:0] coef0 = '0, coef1 = '0;
    logic ack0, ack1, done0, done1, err, busy, gnt, eng_start;
    logic signed [31:0] result;
    logic [35:0] eng_coef;
    logic eng_ready, eng_done;
    logic signed [31:0] eng_out;

    int checks = 0;
    int failures = 0;

    babbage_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .coef0(coef0), .coef1(coef1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .result(result), .err(err),
        .busy(busy), .gnt(gnt), .eng_start(eng_start), .eng_coef(eng_coef),
        .eng_ready(eng_ready), .eng_done(eng_done), .eng_out(eng_out)
    );

    always #5 clk = ~clk;

    // u(n) = a n^5 + b n^4 + c n^3 + d n^2 + f n + g, wrapped to 32 bits
    function automatic logic signed [31:0] poly(input logic [35:0] v);
        coef_t cf;
        longint n, s;
        cf = coef_t'(v);
        n = longint'(cf.n);
        s = longint'($signed(cf.a)) * n**5 + longint'($signed(cf.b)) * n**4
          + longint'($signed(cf.c)) * n**3 + longint'($signed(cf.d)) * n**2
          + longint'($signed(cf.f)) * n + longint'($signed(cf.g));
        return $signed(32'(s));
    endfunction

    function automatic logic [35:0] rand_coef();
        return 36'({$urandom(), $urandom()});
    endfunction

    // Engine stub: latency eng_lat after eng_start, optional stall, no reset of its own
    int eng_lat = 3;
    bit eng_stall = 0, ready_force = 1, inj_done = 0, eng_run = 0;
    int eng_cnt = 0;
    logic [35:0] eng_c = '0;
    logic eng_done_q = 1'b0;
    logic signed [31:0] eng_out_q = '0, inj_out = '0;

    always @(posedge clk) begin
        eng_done_q <= 1'b0;
        if (eng_start) begin
            eng_run <= 1'b1;
            eng_cnt <= eng_lat;
            eng_c   <= eng_coef;
        end else if (eng_run && !eng_stall) begin
            if (eng_cnt <= 1) begin
                eng_done_q <= 1'b1;
                eng_out_q  <= poly(eng_c);
                eng_run    <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    assign eng_ready = ready_force & (!eng_run | eng_stall);
    assign eng_done  = eng_done_q | inj_done;
    assign eng_out   = inj_done ? inj_out : eng_out_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0; ready_force = 1; eng_stall = 0; inj_done = 0;
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #2;
        checks++;
        if ({ack0, ack1, done0, done1, busy, gnt, err, eng_start} !== 8'h00) begin
            failures++; $display("FAIL reset_ctl got=%b want=00000000", {ack0, ack1, done0, done1, busy, gnt, err, eng_start});
        end
        checks++;
        if (result !== 32'sd0 || eng_coef !== 36'd0) begin
            failures++; $display("FAIL reset_data result=%0d coef=%h want 0/0", result, eng_coef);
        end
        repeat (2) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({ack0, ack1, done0, done1, busy, eng_start} !== 6'h00) begin
            failures++; $display("FAIL reset_idle got=%b want=000000", {ack0, ack1, done0, done1, busy, eng_start});
        end
    endtask

    task automatic test_single();
        coef_t cc;
        int n_ack0 = 0, n_ack1 = 0, n_start = 0, n_done0 = 0, n_done1 = 0, ack_at = -1, done_at = -1;
        logic signed [31:0] res = '0;
        cc.a = -2'sd1; cc.b = 3'sd2; cc.c = 4'sd5; cc.d = 4'sd7;
        cc.f = 6'sd29; cc.g = 10'sd219; cc.n = 7'd54;
        do_reset();
        coef0 = cc; eng_lat = 5; req0 = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (ack0) begin n_ack0++; if (ack_at < 0) ack_at = k; req0 = 1'b0; end
            if (ack1) n_ack1++;
            if (eng_start) n_start++;
            if (done0) begin n_done0++; done_at = k; res = result; end
            if (done1) n_done1++;
        end
        checks++;
        if (ack_at != 1 || n_ack0 != 1 || n_ack1 != 0) begin
            failures++; $display("FAIL single_ack at=%0d n0=%0d n1=%0d want 1/1/0", ack_at, n_ack0, n_ack1);
        end
        checks++;
        if (n_start != 1) begin failures++; $display("FAIL single_start got=%0d want=1", n_start); end
        checks++;
        if (n_done0 != 1 || n_done1 != 0 || done_at != 8) begin
            failures++; $display("FAIL single_done n0=%0d n1=%0d at=%0d want 1/0/8", n_done0, n_done1, done_at);
        end
        checks++;
        if (res !== -32'sd441349395) begin failures++; $display("FAIL single_result got=%0d want=-441349395", res); end
        checks++;
        if (result !== -32'sd441349395 || busy !== 1'b0 || gnt !== 1'b0) begin
            failures++; $display("FAIL single_hold result=%0d busy=%b gnt=%b want -441349395/0/0", result, busy, gnt);
        end
    endtask

    task automatic test_tie();
        logic [3:0] ord = '0;
        logic [35:0] pend = '0;
        logic w, d;
        int n_ack = 0, n_done = 0, last_done = -1;
        do_reset();
        eng_lat = 2; coef0 = rand_coef(); coef1 = rand_coef();
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 1; k <= 150 && n_done < 4; k++) begin
            tick();
            if (ack0 || ack1) begin
                w = ack1;
                checks++;
                if ((ack0 && ack1) || gnt !== w || eng_coef !== (w ? coef1 : coef0)) begin
                    failures++; $display("FAIL tie_ack ack=%b%b gnt=%b coef=%h", ack0, ack1, gnt, eng_coef);
                end
                if (last_done >= 0) begin
                    checks++;
                    if (k - last_done != 2) begin failures++; $display("FAIL tie_gap got=%0d want=2", k - last_done); end
                end
                if (n_ack < 4) ord[n_ack] = w;
                n_ack++;
                pend = w ? coef1 : coef0;
                if (w) coef1 = rand_coef(); else coef0 = rand_coef();
            end
            if (done0 || done1) begin
                d = done1;
                checks++;
                if ((done0 && done1) || gnt !== d || n_ack == 0 || ord[n_done] !== d || result !== poly(pend)) begin
                    failures++; $display("FAIL tie_done done=%b%b gnt=%b result=%0d want=%0d", done0, done1, gnt, result, poly(pend));
                end
                n_done++; last_done = k;
                if (n_done == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        checks++;
        if (n_done != 4 || n_ack != 4 || ord !== 4'b1010) begin
            failures++; $display("FAIL tie_order acks=%0d dones=%0d order=%b want 4/4/1010", n_ack, n_done, ord);
        end
        repeat (6) tick();
    endtask

    task automatic test_withdraw();
        int n_ack1 = 0, n_done0 = 0, n_done1 = 0, done_at = -1;
        do_reset();
        eng_lat = 6; coef0 = rand_coef(); coef1 = rand_coef(); req0 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ack0) req0 = 1'b0;
            if (ack1) n_ack1++;
            if (done1) n_done1++;
            if (done0) begin n_done0++; done_at = k; end
            if (done_at > 0 && k == done_at + 1) begin
                checks++;
                if (busy !== 1'b0) begin failures++; $display("FAIL withdraw_busy got=%b want=0", busy); end
            end
            if (k == 3) req1 = 1'b1;
            if (k == 6) req1 = 1'b0;
        end
        checks++;
        if (n_ack1 != 0 || n_done1 != 0 || n_done0 != 1 || done_at != 9) begin
            failures++; $display("FAIL withdraw_pulses ack1=%0d done1=%0d done0=%0d at=%0d want 0/0/1/9", n_ack1, n_done1, n_done0, done_at);
        end
    endtask

    task automatic test_ready();
        int n_early = 0;
        do_reset();
        ready_force = 0; eng_lat = 1; coef0 = rand_coef(); req0 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (ack0 || ack1 || busy) n_early++;
        end
        checks++;
        if (n_early != 0) begin failures++; $display("FAIL ready_hold got=%0d want=0", n_early); end
        ready_force = 1;
        tick();
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || eng_coef !== coef0) begin
            failures++; $display("FAIL ready_ack ack=%b%b coef=%h want 10/%h", ack0, ack1, eng_coef, coef0);
        end
        req0 = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_spurious();
        logic signed [31:0] r;
        int bad = 0, n_done0 = 0;
        do_reset();
        eng_lat = 3; coef0 = rand_coef(); req0 = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            inj_done = 0;
            if (ack0) begin
                req0 = 1'b0; inj_out = ~poly(coef0); inj_done = 1;
            end
            if (done0) begin
                n_done0++;
                checks++;
                if (result !== poly(coef0)) begin failures++; $display("FAIL spur_launch got=%0d want=%0d", result, poly(coef0)); end
            end
        end
        r = poly(coef0);
        inj_out = ~r; inj_done = 1;
        tick();
        inj_done = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done0 || done1 || busy || result !== r) bad++;
        end
        checks++;
        if (bad != 0 || n_done0 != 1) begin failures++; $display("FAIL spur_idle bad=%0d done0=%0d want 0/1", bad, n_done0); end
    endtask

    task automatic test_async_reset();
        int n_done = 0, n_ack = 0;
        do_reset();
        eng_lat = 4; coef0 = rand_coef() | 36'd1; req0 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ack0) begin n_ack++; req0 = 1'b0; end
            if (done0) begin req0 = 1'b1; coef0 = rand_coef() | 36'd1; end
            if (n_ack == 2 && k >= 3 && busy) break;
        end
        tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({ack0, ack1, done0, done1, busy, gnt, err, eng_start} !== 8'h00 || result !== 32'sd0 || eng_coef !== 36'd0) begin
            failures++; $display("FAIL async_reset ctl=%b result=%0d coef=%h want 0", {ack0, ack1, done0, done1, busy, gnt, err, eng_start}, result, eng_coef);
        end
        req0 = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done0 || done1 || ack0 || ack1) n_done++;
        end
        checks++;
        if (n_done != 0) begin failures++; $display("FAIL reset_discard pulses=%0d want=0", n_done); end
    endtask

    task automatic test_random();
        logic [35:0] job [2];
        logic [35:0] own_coef = '0;
        logic signed [31:0] exp_res = '0;
        bit rq [2];
        int wait_c [2];
        int owner = -1, hold = 0, jobs = 0;
        logic last_w = 1'b1, win;
        bit launch = 0, p0, p1, rdy, can, edge_done, exp_ack, expd;
        logic [5:0] exp_v;
        do_reset();
        for (int r = 0; r < 2; r++) begin rq[r] = 0; wait_c[r] = $urandom_range(0, 4); job[r] = '0; end
        for (int c = 0; c < 4000 && jobs < 60; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!rq[r]) begin
                    if (wait_c[r] == 0) begin rq[r] = 1; job[r] = rand_coef(); end
                    else wait_c[r]--;
                end else if ($urandom_range(0, 19) == 0) begin
                    rq[r] = 0; wait_c[r] = $urandom_range(0, 4);
                end
            end
            req0 = rq[0]; req1 = rq[1]; coef0 = job[0]; coef1 = job[1];
            ready_force = ($urandom_range(0, 9) != 0);
            eng_lat = $urandom_range(1, 5);
            p0 = rq[0]; p1 = rq[1];
            rdy = ready_force & (!eng_run | eng_stall);
            can = (owner < 0) && (hold == 0);
            edge_done = eng_done_q && (owner >= 0) && !launch;
            tick();
            if (hold > 0) hold--;
            launch = 0;
            exp_ack = can && (p0 || p1) && rdy;
            win = (p0 && p1) ? ~last_w : logic'(p1);
            expd = edge_done;
            if (expd) exp_res = poly(own_coef);
            exp_v = {exp_ack && !win, exp_ack && win, expd && owner == 0, expd && owner == 1, exp_ack, exp_ack || owner >= 0};
            checks++;
            if ({ack0, ack1, done0, done1, eng_start, busy, result} !== {exp_v, exp_res}) begin
                failures++; $display("FAIL rand_ctl cyc=%0d got=%b/%0d want=%b/%0d", c, {ack0, ack1, done0, done1, eng_start, busy}, result, exp_v, exp_res);
            end
            if (exp_ack) begin
                checks++;
                if (eng_coef !== job[win] || gnt !== win) begin
                    failures++; $display("FAIL rand_launch cyc=%0d coef=%h gnt=%b want %h/%b", c, eng_coef, gnt, job[win], win);
                end
                owner = win ? 1 : 0; last_w = win; own_coef = job[win]; launch = 1;
                rq[win] = 0; wait_c[win] = $urandom_range(0, 4);
            end
            if (expd) begin owner = -1; hold = 1; jobs++; end
        end
        req0 = 1'b0; req1 = 1'b0; ready_force = 1;
        repeat (12) tick();
        checks++;
        if (jobs < 20) begin failures++; $display("FAIL rand_progress jobs=%0d want>=20", jobs); end
    endtask

`ifdef BABBAGE_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int ack_at = -1, done_at = -1, n_ack = 0;
        logic signed [31:0] r = '1;
        logic e = 1'b0;
        do_reset();
        eng_lat = 2; coef0 = rand_coef() | 36'd1; req0 = 1'b1;
        for (int k = 1; k <= 10; k++) begin tick(); if (ack0) req0 = 1'b0; end
        eng_stall = 1; coef0 = rand_coef(); req0 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ack0) begin req0 = 1'b0; ack_at = k; end
            if (done0 && done_at < 0) begin done_at = k; r = result; e = err; end
        end
        checks++;
        if (ack_at < 0 || done_at - ack_at != 9) begin
            failures++; $display("FAIL timeout_lat ack=%0d done=%0d want gap 9", ack_at, done_at);
        end
        checks++;
        if (r !== 32'sd0 || e !== 1'b1 || err !== 1'b1) begin
            failures++; $display("FAIL timeout_flag result=%0d err=%b/%b want 0/1/1", r, e, err);
        end
        eng_stall = 0;
        repeat (6) tick();
        req0 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (ack0 && n_ack == 0) begin
                n_ack++; req0 = 1'b0;
                checks++;
                if (err !== 1'b0) begin failures++; $display("FAIL timeout_clear err=%b want=0", err); end
            end
        end
        checks++;
        if (n_ack != 1) begin failures++; $display("FAIL timeout_reack got=%0d want=1", n_ack); end
        repeat (10) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_withdraw();
        test_ready();
        test_spurious();
        test_async_reset();
`ifdef BABBAGE_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
